// File: rtl/abl_pkg.sv
// Shared definitions for the address-bus-low sequencer: ABL op codes, addressing modes,
// register-file selects and the sequencer state enum.
// Latency: n/a (definitions only). Backpressure: n/a.
package abl_pkg;

    // ABL op codes driven onto the datapath
    localparam logic [4:0] OP_HOLD   = 5'b00011;  // ABL holds (ci=0) or advances (ci=1)
    localparam logic [4:0] OP_DBREG  = 5'b00101;  // DB + REG
    localparam logic [4:0] OP_AHLREG = 5'b01001;  // AHL + REG
    localparam logic [4:0] OP_BR     = 5'b01111;  // branch add; bit 4 carries the branch sense
    localparam logic [4:0] OP_REG    = 5'b00001;  // REG + 0
    localparam logic [4:0] OP_PC     = 5'b00010;  // PCL + 0

    // Addressing modes as presented by the decoder
    localparam logic [2:0] MODE_ZP   = 3'd0;
    localparam logic [2:0] MODE_ZPX  = 3'd1;
    localparam logic [2:0] MODE_ZPY  = 3'd2;
    localparam logic [2:0] MODE_ABS  = 3'd3;
    localparam logic [2:0] MODE_ABSX = 3'd4;
    localparam logic [2:0] MODE_ABSY = 3'd5;
    localparam logic [2:0] MODE_REL  = 3'd6;
    localparam logic [2:0] MODE_STK  = 3'd7;

    // Register-file index selects
    localparam logic [1:0] REG_ZERO = 2'd0;
    localparam logic [1:0] REG_X    = 2'd1;
    localparam logic [1:0] REG_Y    = 2'd2;
    localparam logic [1:0] REG_S    = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OPND,
        S_OPND2,
        S_EA_ZP,
        S_EA_ABS,
        S_BR,
        S_FIX,
        S_DATA,
        S_STK,
        S_RESTORE
    } state_t;

    // Index register implied by a mode. Stack mode points at S throughout the
    // sequence; modes without an index add zero.
    function automatic logic [1:0] reg_sel_of(input logic [2:0] m);
        logic [1:0] r;
        r = REG_ZERO;
        case (m)
            MODE_ZPX, MODE_ABSX: r = REG_X;
            MODE_ZPY, MODE_ABSY: r = REG_Y;
            MODE_STK:            r = REG_S;
            default:             r = REG_ZERO;
        endcase
        return r;
    endfunction

    function automatic logic is_abs(input logic [2:0] m);
        return (m == MODE_ABS) || (m == MODE_ABSX) || (m == MODE_ABSY);
    endfunction

endpackage

// File: rtl/abl_seq.sv
// ABL sequencer: steps one state per rdy cycle from a start pulse, decoding ABL op/ci, AHL/PCL loads, reg select, ABH fix.
// Latency: start->done 4 (ZP*), 5/6 (ABS*), 2/3 (REL), 2 (STK) cycles; outputs are combinational from state.
// Backpressure: rdy=0 freezes state and forces HOLD with all enables and done low; start is not queued.
// Ports: clk/RST (async active-high); start, mode, br_inv from decoder; rdy bus stall; co from ABL adder;
//        op, ci, ld_ahl, ld_pc, inc_pc, reg_sel, abh_inc to the datapath; busy, done status.
module abl_seq
    import abl_pkg::*;
#(
    parameter bit FIX_EN = 1'b1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic [2:0] mode,
    input  logic       br_inv,
    input  logic       rdy,
    input  logic       co,
    output logic [4:0] op,
    output logic       ci,
    output logic       ld_ahl,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic [1:0] reg_sel,
    output logic       abh_inc,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [2:0] mode_q;
    logic       br_inv_q;
    logic       fix_ret_idle;   // FIX returns to IDLE (branch) rather than DATA (absolute)
    logic       take_fix;

    // co only matters at the edge that ends EA_ABS/BR; elsewhere it is ignored.
    assign take_fix = co && FIX_EN;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            mode_q       <= MODE_ZP;
            br_inv_q     <= 1'b0;
            fix_ret_idle <= 1'b0;
        end else if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        br_inv_q <= br_inv;
                        state    <= (mode == MODE_STK) ? S_STK : S_OPND;
                    end
                end
                S_OPND: begin
                    if (mode_q == MODE_REL)
                        state <= S_BR;
                    else if (is_abs(mode_q))
                        state <= S_OPND2;
                    else
                        state <= S_EA_ZP;
                end
                S_OPND2: state <= S_EA_ABS;
                // Zero page wraps inside page 0, so no page fix here.
                S_EA_ZP: state <= S_DATA;
                S_EA_ABS: begin
                    if (take_fix) begin
                        state        <= S_FIX;
                        fix_ret_idle <= 1'b0;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_BR: begin
                    if (take_fix) begin
                        state        <= S_FIX;
                        fix_ret_idle <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FIX:     state <= fix_ret_idle ? S_IDLE : S_DATA;
                S_DATA:    state <= S_RESTORE;
                S_STK:     state <= S_RESTORE;
                S_RESTORE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        op      = OP_HOLD;
        ci      = 1'b0;
        ld_ahl  = 1'b0;
        ld_pc   = 1'b0;
        inc_pc  = 1'b0;
        abh_inc = 1'b0;
        done    = 1'b0;
        reg_sel = reg_sel_of(mode_q);

        case (state)
            S_OPND: begin
                ci     = 1'b1;
                ld_pc  = 1'b1;
                inc_pc = 1'b1;
            end
            S_OPND2: begin
                ci     = 1'b1;
                ld_ahl = 1'b1;
                ld_pc  = 1'b1;
                inc_pc = 1'b1;
            end
            S_EA_ZP:  op = OP_DBREG;
            S_EA_ABS: op = OP_AHLREG;
            S_BR: begin
                op    = {br_inv_q, OP_BR[3:0]};
                ci    = 1'b1;
                ld_pc = 1'b1;
                // Without a page cross the branch completes here.
                done  = !take_fix;
            end
            S_FIX: begin
                abh_inc = 1'b1;
                done    = fix_ret_idle;
            end
            S_STK: begin
                op      = OP_REG;
                reg_sel = REG_S;
            end
            S_RESTORE: begin
                op   = OP_PC;
                done = 1'b1;
            end
            default: begin
                op = OP_HOLD;
            end
        endcase

        // Stall: ABL holds and nothing loads; reg_sel keeps the state's value.
        if (!rdy) begin
            op      = OP_HOLD;
            ci      = 1'b0;
            ld_ahl  = 1'b0;
            ld_pc   = 1'b0;
            inc_pc  = 1'b0;
            abh_inc = 1'b0;
            done    = 1'b0;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_abl_seq.sv
module tb_abl_seq;
    import abl_pkg::*;

    logic       clk = 1'b0;
    logic       RST;
    logic       start;
    logic [2:0] mode;
    logic       br_inv;
    logic       rdy;
    logic       co;

    // dut1: FIX_EN=1, dut0: FIX_EN=0, both driven by the same stimulus
    logic [4:0] op1, op0;
    logic       ci1, ci0, ld_ahl1, ld_ahl0, ld_pc1, ld_pc0, inc_pc1, inc_pc0;
    logic [1:0] reg_sel1, reg_sel0;
    logic       abh_inc1, abh_inc0, busy1, busy0, done1, done0;

    always #5 clk = ~clk;

    abl_seq #(.FIX_EN(1'b1)) dut1 (
        .clk(clk), .RST(RST), .start(start), .mode(mode), .br_inv(br_inv), .rdy(rdy), .co(co),
        .op(op1), .ci(ci1), .ld_ahl(ld_ahl1), .ld_pc(ld_pc1), .inc_pc(inc_pc1),
        .reg_sel(reg_sel1), .abh_inc(abh_inc1), .busy(busy1), .done(done1)
    );

    abl_seq #(.FIX_EN(1'b0)) dut0 (
        .clk(clk), .RST(RST), .start(start), .mode(mode), .br_inv(br_inv), .rdy(rdy), .co(co),
        .op(op0), .ci(ci0), .ld_ahl(ld_ahl0), .ld_pc(ld_pc0), .inc_pc(inc_pc0),
        .reg_sel(reg_sel0), .abh_inc(abh_inc0), .busy(busy0), .done(done0)
    );

    // Output word: {op[4:0], ci, ld_ahl, ld_pc, inc_pc, reg_sel[1:0], abh_inc, done}
    logic [12:0] q1[$];
    logic [12:0] q0[$];
    logic [1:0]  last_rs1, last_rs0;
    int checks = 0;
    int failures = 0;

    function automatic logic [12:0] w(input logic [4:0] o, input logic c, input logic la,
                                      input logic lp, input logic ip, input logic [1:0] rs,
                                      input logic ab, input logic d);
        return {o, c, la, lp, ip, rs, ab, d};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] mode_rs(input logic [2:0] m);
        case (m)
            3'd1, 3'd4: return 2'd1;
            3'd2, 3'd5: return 2'd2;
            3'd7:       return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    // Reference: the list of per-active-cycle outputs for one accepted start.
    task automatic model(input int k, input logic [2:0] m, input logic b, input logic c);
        logic [12:0] s[$];
        logic [1:0]  rs;
        logic        fx;
        rs = mode_rs(m);
        fx = c && (k == 1);
        if (m <= 3'd2) begin
            s.push_back(w(5'b00011, 1, 0, 1, 1, rs, 0, 0));
            s.push_back(w(5'b00101, 0, 0, 0, 0, rs, 0, 0));
            s.push_back(w(5'b00011, 0, 0, 0, 0, rs, 0, 0));
            s.push_back(w(5'b00010, 0, 0, 0, 0, rs, 0, 1));
        end else if (m <= 3'd5) begin
            s.push_back(w(5'b00011, 1, 0, 1, 1, rs, 0, 0));
            s.push_back(w(5'b00011, 1, 1, 1, 1, rs, 0, 0));
            s.push_back(w(5'b01001, 0, 0, 0, 0, rs, 0, 0));
            if (fx) s.push_back(w(5'b00011, 0, 0, 0, 0, rs, 1, 0));
            s.push_back(w(5'b00011, 0, 0, 0, 0, rs, 0, 0));
            s.push_back(w(5'b00010, 0, 0, 0, 0, rs, 0, 1));
        end else if (m == 3'd6) begin
            s.push_back(w(5'b00011, 1, 0, 1, 1, rs, 0, 0));
            s.push_back(w({b, 4'b1111}, 1, 0, 1, 0, rs, 0, !fx));
            if (fx) s.push_back(w(5'b00011, 0, 0, 0, 0, rs, 1, 1));
        end else begin
            s.push_back(w(5'b00001, 0, 0, 0, 0, 2'd3, 0, 0));
            s.push_back(w(5'b00010, 0, 0, 0, 0, 2'd3, 0, 1));
        end
        foreach (s[i]) begin
            if (k == 1) q1.push_back(s[i]);
            else        q0.push_back(s[i]);
        end
        if (k == 1) last_rs1 = rs;
        else        last_rs0 = rs;
    endtask

    function automatic int latency(input int k, input logic [2:0] m, input logic c);
        int fx;
        fx = (c && k == 1) ? 1 : 0;
        if (m <= 3'd2) return 4;
        if (m <= 3'd5) return 5 + fx;
        if (m == 3'd6) return 2 + fx;
        return 2;
    endfunction

    task automatic mon(input int k, input logic [12:0] act, input logic b);
        logic [12:0] e;
        int n;
        n = (k == 1) ? q1.size() : q0.size();
        if (!b) begin
            chk($sformatf("idle_pending_dut%0d", k), n, 0);
            chk($sformatf("idle_outputs_dut%0d", k), 32'(act),
                32'(w(5'b00011, 0, 0, 0, 0, (k == 1) ? last_rs1 : last_rs0, 0, 0)));
        end else if (n == 0) begin
            chk($sformatf("unexpected_busy_dut%0d", k), 32'(b), 0);
        end else if (rdy) begin
            e = (k == 1) ? q1.pop_front() : q0.pop_front();
            chk($sformatf("step_dut%0d", k), 32'(act), 32'(e));
        end else begin
            e = (k == 1) ? q1[0] : q0[0];
            chk($sformatf("stall_dut%0d", k), 32'(act),
                32'(w(5'b00011, 0, 0, 0, 0, e[3:2], 0, 0)));
        end
    endtask

    always @(negedge clk) begin
        if (!RST) begin
            mon(1, {op1, ci1, ld_ahl1, ld_pc1, inc_pc1, reg_sel1, abh_inc1, done1}, busy1);
            mon(0, {op0, ci0, ld_ahl0, ld_pc0, inc_pc0, reg_sel0, abh_inc0, done0}, busy0);
        end
    end

    // kind: 0 no stall, 1 random stall and spurious starts, 2 three-cycle stall in OPND2
    task automatic run_txn(input logic [2:0] m, input logic b, input logic c, input int kind);
        int lat1, lat0;
        logic fin;
        @(posedge clk); #1;
        mode = m; br_inv = b; co = c; start = 1'b1; rdy = 1'b1;
        @(posedge clk);
        model(1, m, b, c);
        model(0, m, b, c);
        #1;
        start = 1'b0;
        mode = 3'($urandom);
        br_inv = 1'($urandom);
        lat1 = 0; lat0 = 0; fin = 1'b0;
        for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
            case (kind)
                1:       rdy = ($urandom % 4) != 0;
                2:       rdy = !(cyc >= 2 && cyc <= 4);
                default: rdy = 1'b1;
            endcase
            start = 1'b0;
            if (busy1 && busy0) begin
                if (kind == 1 && ($urandom % 5) == 0) start = 1'b1;
                if (kind == 2 && cyc == 6) start = 1'b1;
            end
            @(negedge clk);
            if (done1 && lat1 == 0) lat1 = cyc;
            if (done0 && lat0 == 0) lat0 = cyc;
            @(posedge clk); #1;
            if (!busy1 && !busy0 && q1.size() == 0 && q0.size() == 0) fin = 1'b1;
        end
        start = 1'b0;
        rdy = 1'b1;
        chk("txn_completes", 32'(fin), 1);
        if (kind != 1) begin
            chk($sformatf("latency_dut1_mode%0d", m), lat1, latency(1, m, c) + (kind == 2 ? 3 : 0));
            chk($sformatf("latency_dut0_mode%0d", m), lat0, latency(0, m, c) + (kind == 2 ? 3 : 0));
        end
        co = 1'($urandom);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; rdy = 1'b0; co = 1'b0; mode = 3'd0; br_inv = 1'b0;
        last_rs1 = 2'd0; last_rs0 = 2'd0;
        #2;
        chk("reset_out_dut1", 32'({op1, ci1, ld_ahl1, ld_pc1, inc_pc1, reg_sel1, abh_inc1, done1}),
            32'(w(5'b00011, 0, 0, 0, 0, 0, 0, 0)));
        chk("reset_out_dut0", 32'({op0, ci0, ld_ahl0, ld_pc0, inc_pc0, reg_sel0, abh_inc0, done0}),
            32'(w(5'b00011, 0, 0, 0, 0, 0, 0, 0)));
        chk("reset_busy_dut1", 32'(busy1), 0);
        chk("reset_busy_dut0", 32'(busy0), 0);
        @(posedge clk); #1;
        RST = 1'b0; rdy = 1'b1;

        run_txn(3'd1, 1'b0, 1'b1, 0);   // ZPX, co ignored in EA_ZP
        run_txn(3'd5, 1'b0, 1'b1, 0);   // ABSY with page cross
        run_txn(3'd4, 1'b0, 1'b0, 0);   // ABSX no cross
        run_txn(3'd6, 1'b1, 1'b0, 0);   // REL inverted, no cross
        run_txn(3'd6, 1'b1, 1'b1, 0);   // REL inverted, cross
        run_txn(3'd7, 1'b0, 1'b0, 0);   // STK
        run_txn(3'd3, 1'b0, 1'b0, 2);   // ABS, stall in OPND2, start while busy

        // start with rdy=0 in IDLE must not be taken
        @(posedge clk); #1;
        start = 1'b1; rdy = 1'b0; mode = 3'd3;
        @(posedge clk); #1;
        start = 1'b0; rdy = 1'b1;
        chk("start_nordy_busy_dut1", 32'(busy1), 0);
        chk("start_nordy_busy_dut0", 32'(busy0), 0);

        // async reset in EA_ABS
        @(posedge clk); #1;
        mode = 3'd3; br_inv = 1'b0; co = 1'b1; start = 1'b1; rdy = 1'b1;
        @(posedge clk);
        model(1, 3'd3, 1'b0, 1'b1);
        model(0, 3'd3, 1'b0, 1'b1);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 RST = 1'b1;
        #1;
        chk("async_rst_busy_dut1", 32'(busy1), 0);
        chk("async_rst_busy_dut0", 32'(busy0), 0);
        chk("async_rst_out_dut1", 32'({op1, ci1, ld_ahl1, ld_pc1, inc_pc1, reg_sel1, abh_inc1, done1}),
            32'(w(5'b00011, 0, 0, 0, 0, 0, 0, 0)));
        chk("async_rst_out_dut0", 32'({op0, ci0, ld_ahl0, ld_pc0, inc_pc0, reg_sel0, abh_inc0, done0}),
            32'(w(5'b00011, 0, 0, 0, 0, 0, 0, 0)));
        q1.delete();
        q0.delete();
        last_rs1 = 2'd0;
        last_rs0 = 2'd0;
        @(posedge clk); #1;
        RST = 1'b0;
        run_txn(3'd0, 1'b0, 1'b0, 0);   // normal ZP after reset

        for (int i = 0; i < 40; i++) begin
            run_txn(3'($urandom), 1'($urandom), 1'($urandom), int'($urandom % 2));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/abl_seq.md
Name: abl_seq

Overview:
- Sequencer for the address-bus-low datapath.
- Takes a start pulse and a 3-bit addressing mode, then steps a state machine one state per enabled cycle.
- Each state drives the ABL op code, carry-in, AHL/PCL load controls, register-file index select and the ABH page-fix request.
- Sits between the instruction decoder and the ABL/ABH datapath slices; honours the bus RDY stall.

Parameters:
- FIX_EN, 1, 1 = insert FIX cycle on CO from EA/BR; 0 = never enter FIX (abh_inc stays 0).

Ports:
- clk      input   1  system clock, rising edge
- RST      input   1  asynchronous, active-high reset
- start    input   1  begin sequence; sampled only in IDLE with rdy=1
- mode     input   3  0 ZP, 1 ZPX, 2 ZPY, 3 ABS, 4 ABSX, 5 ABSY, 6 REL, 7 STK; latched with start
- br_inv   input   1  branch sense invert; latched with start; drives op[4] in BR
- rdy      input   1  bus ready; 0 stalls the sequencer
- co       input   1  combinational carry-out from the ABL datapath
- op       output  5  ABL op code
- ci       output  1  ABL carry-in
- ld_ahl   output  1  load AHL from DB
- ld_pc    output  1  load PCL
- inc_pc   output  1  PCL = ABL+1 when loaded
- reg_sel  output  2  0 zero, 1 X, 2 Y, 3 S
- abh_inc  output  1  request ABH increment (page cross)
- busy     output  1  state != IDLE
- done     output  1  one-cycle pulse on final state with rdy=1

Behaviour:
- Outputs are combinational decode of the registered state plus the latched mode/br_inv.
- Only state, mode_q, br_inv_q and FIX-return are flops.
- HOLD encoding: op=00011, ci=0 (ABL holds). ADV encoding: op=00011, ci=1 (ABL+1).
- Defaults in every state unless listed: ld_ahl=0, ld_pc=0, inc_pc=0, abh_inc=0, reg_sel=reg_sel(mode_q).
- Reset: state=IDLE, mode_q=0, br_inv_q=0. Outputs: op=00011, ci=0, all enables 0, busy=0, done=0.
- States and outputs:
  - IDLE: HOLD.
  - OPND: ADV, ld_pc=1, inc_pc=1.
  - OPND2: ADV, ld_ahl=1, ld_pc=1, inc_pc=1.
  - EA_ZP: op=00101 (DB+REG), ci=0.
  - EA_ABS: op=01001 (AHL+REG), ci=0.
  - BR: op={br_inv_q,4'b1111}, ci=1, ld_pc=1, inc_pc=0.
  - FIX: HOLD, abh_inc=1.
  - DATA: HOLD.
  - STK: op=00001 (REG+0), ci=0, reg_sel=3.
  - RESTORE: op=00010 (PCL+0), ci=0.
- Transitions (only when rdy=1):
  - IDLE: start → OPND (STK mode → STK).
  - OPND: ZP* → EA_ZP; ABS* → OPND2; REL → BR.
  - OPND2 → EA_ABS.
  - EA_ZP → DATA.
  - EA_ABS: co & FIX_EN → FIX(ret DATA), else → DATA.
  - BR: co & FIX_EN → FIX(ret IDLE), else → IDLE with done.
  - FIX → return target; if return is IDLE, done pulses in FIX.
  - DATA → RESTORE.
  - STK → RESTORE.
  - RESTORE → IDLE with done.
- EA_ZP ignores co: zero-page wraps within page 0, no FIX.
- Stall: rdy=0 holds state. Outputs are forced to HOLD with ld_ahl=ld_pc=inc_pc=abh_inc=done=0; reg_sel is unchanged.
- start while busy is ignored; start with rdy=0 in IDLE is ignored (not queued).
- co is sampled at the clock edge ending EA_ABS/BR; co in any other state is ignored.
- Asynchronous RST mid-sequence returns to IDLE immediately; the pending done is lost.
- Latency start→done (no stall, no fix):
  - ZP/ZPX/ZPY: 4 cycles after the start edge.
  - ABS*: 5 cycles; +1 with fix.
  - REL: 2 cycles; +1 with fix.
  - STK: 2 cycles.

Decomposition:
- Shared package abl_pkg holds:
  - op constants: OP_HOLD=00011, OP_DBREG=00101, OP_AHLREG=01001, OP_BR=01111, OP_REG=00001, OP_PC=00010.
  - mode encodings.
  - reg_sel encodings.
  - state enum.
- No sub-module: single FSM with output decode.

Test Plan:
- ZPX: start, mode=1, rdy=1 → states OPND, EA_ZP, DATA, RESTORE. EA_ZP shows op=00101, reg_sel=1. done pulses in the 4th cycle; co=1 in EA_ZP gives no FIX.
- ABSY with co=1 in EA_ABS → OPND2 asserts ld_ahl=1. EA_ABS op=01001, reg_sel=2. FIX asserts abh_inc=1 for 1 cycle, then DATA, RESTORE; done at cycle 6. Repeat with FIX_EN=0 → done at cycle 5, abh_inc never 1.
- REL, br_inv=1, co=0 → BR shows op=11111, ci=1, done at cycle 2. With co=1 → FIX then done at cycle 3.
- STK: mode=7 → STK op=00001, reg_sel=3, ci=0, then RESTORE op=00010; done at cycle 2.
- Stall: ABS with rdy=0 for 3 cycles during OPND2 → state held. Outputs are op=00011, ci=0, ld_ahl=0, ld_pc=0. Completion is delayed exactly 3 cycles; second start pulse while busy is ignored.
- Reset: RST asserted asynchronously in EA_ABS → busy=0, op=00011, done=0 before next edge. Next start, mode=0 runs a normal ZP sequence.
